// File: rtl/fsk_link_framer_pkg.sv
// Shared word width, default timing parameters and FSM encodings for the FSK link framer.
package fsk_link_framer_pkg;

  localparam int WORD_W           = 11;
  localparam int DEF_CLK_DIV      = 32;
  localparam int DEF_BIT_CYCLES   = 16;
  localparam int DEF_SAMPLE_PHASE = DEF_BIT_CYCLES / 2;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/fsk_tx_serializer.sv
// Edge-triggered serializer: latches an 11-bit codeword and shifts it out MSB first,
// one bit per BIT_CYCLES clocks, with sending high for the whole frame.
module fsk_tx_serializer
  import fsk_link_framer_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] code_i,
  input  logic              send_i,
  output logic              codeout_o,
  output logic              sending_o
);

  localparam int PW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(WORD_W);

  tx_state_e         state_q, state_d;
  logic              send_q;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              codeout_q, codeout_d;
  logic              send_rise;
  logic              bit_end;
  logic              last_bit;

  assign send_rise = send_i & ~send_q;
  assign bit_end   = (cyc_q == PW'(BIT_CYCLES - 1));
  assign last_bit  = (bit_q == BW'(WORD_W - 1));

  // State and datapath registers; send_q resets high so a held send cannot start a frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TX_IDLE;
      send_q    <= 1'b1;
      shreg_q   <= '0;
      cyc_q     <= '0;
      bit_q     <= '0;
      codeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      send_q    <= send_i;
      shreg_q   <= shreg_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      codeout_q <= codeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: begin
        if (send_rise) state_d = TX_SHIFT;
        else           state_d = TX_IDLE;
      end
      TX_SHIFT: begin
        if (bit_end && last_bit) state_d = TX_IDLE;
        else                     state_d = TX_SHIFT;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    codeout_d = codeout_q;
    case (state_q)
      TX_IDLE: begin
        if (send_rise) begin
          shreg_d   = code_i;
          cyc_d     = '0;
          bit_d     = '0;
          codeout_d = code_i[WORD_W-1];
        end else begin
          codeout_d = 1'b0;
        end
      end
      TX_SHIFT: begin
        if (bit_end) begin
          cyc_d = '0;
          if (last_bit) begin
            bit_d     = '0;
            codeout_d = 1'b0;
          end else begin
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_d     = bit_q + BW'(1);
            codeout_d = shreg_q[WORD_W-2];
          end
        end else begin
          cyc_d = cyc_q + PW'(1);
        end
      end
      default: begin
        shreg_d   = '0;
        cyc_d     = '0;
        bit_d     = '0;
        codeout_d = 1'b0;
      end
    endcase
  end

  assign codeout_o = codeout_q;
  assign sending_o = (state_q == TX_SHIFT);

endmodule

// File: rtl/fsk_link_framer.sv
// FSK link framer: outclk divider, transmit serializer and a receiver that
// reassembles demodulated bits into codewords, gated by the transmit frame.
module fsk_link_framer
  import fsk_link_framer_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int SAMPLE_PHASE = BIT_CYCLES / 2
) (
  input  logic              quickclk,
  input  logic              reset,
  output logic              outclk,
  input  logic [WORD_W-1:0] code,
  input  logic              send,
  output logic              codeout,
  output logic              sending,
  input  logic              decoderes,
  output logic [WORD_W-1:0] codeoutseq,
  output logic              refresh
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int PW   = $clog2(BIT_CYCLES);
  localparam int BW   = $clog2(WORD_W);

  logic [DW-1:0] div_q;
  logic          outclk_q;

  // Half-period counter toggling outclk
  always_ff @(posedge quickclk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      outclk_q <= 1'b0;
    end else if (div_q == DW'(HALF - 1)) begin
      div_q    <= '0;
      outclk_q <= ~outclk_q;
    end else begin
      div_q    <= div_q + DW'(1);
    end
  end

  assign outclk = outclk_q;

  fsk_tx_serializer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_tx (
    .clk_i     (quickclk),
    .rst_i     (reset),
    .code_i    (code),
    .send_i    (send),
    .codeout_o (codeout),
    .sending_o (sending)
  );

  rx_state_e         rx_state_q, rx_state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] rxsh_q, rxsh_d;
  logic [WORD_W-1:0] seq_q, seq_d;
  logic              refresh_q, refresh_d;
  logic              sample_now;
  logic              last_sample;

  assign sample_now  = (phase_q == PW'(SAMPLE_PHASE));
  assign last_sample = (cnt_q == BW'(WORD_W - 1));

  // Receiver registers
  always_ff @(posedge quickclk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      rxsh_q     <= '0;
      seq_q      <= '0;
      refresh_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rxsh_q     <= rxsh_d;
      seq_q      <= seq_d;
      refresh_q  <= refresh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (sending) rx_state_d = RX_COLLECT;
        else         rx_state_d = RX_IDLE;
      end
      RX_COLLECT: begin
        if (!sending)                       rx_state_d = RX_IDLE;
        else if (sample_now && last_sample) rx_state_d = RX_IDLE;
        else                                rx_state_d = RX_COLLECT;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A frame that ends early leaves seq_q untouched, discarding the partial word
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    rxsh_d    = rxsh_q;
    seq_d     = seq_q;
    refresh_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        phase_d = '0;
        cnt_d   = '0;
        if (sending) rxsh_d = '0;
        else         rxsh_d = rxsh_q;
      end
      RX_COLLECT: begin
        if (!sending) begin
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          if (phase_q == PW'(BIT_CYCLES - 1)) phase_d = '0;
          else                                phase_d = phase_q + PW'(1);
          if (sample_now) begin
            rxsh_d = {rxsh_q[WORD_W-2:0], decoderes};
            if (last_sample) begin
              seq_d     = {rxsh_q[WORD_W-2:0], decoderes};
              refresh_d = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d     = cnt_q + BW'(1);
            end
          end else begin
            rxsh_d = rxsh_q;
          end
        end
      end
      default: begin
        phase_d = '0;
        cnt_d   = '0;
        rxsh_d  = '0;
      end
    endcase
  end

  assign codeoutseq = seq_q;
  assign refresh    = refresh_q;

endmodule

// File: tb/tb_fsk_link_framer.sv
// Self-checking bench for fsk_link_framer: frame-level reference model of the
// transmit waveform and the reassembled word, with randomized codewords.
module tb_fsk_link_framer;

  localparam int CLK_DIV = 32;
  localparam int BC      = 16;
  localparam int WW      = 11;
  localparam int FRAME   = WW * BC;

  logic          quickclk = 1'b0;
  logic          reset;
  logic          outclk;
  logic [WW-1:0] code;
  logic          send;
  logic          codeout;
  logic          sending;
  logic          decoderes;
  logic [WW-1:0] codeoutseq;
  logic          refresh;
  logic          lb_en;
  logic          force_val;

  int vectors     = 0;
  int miscompares = 0;

  always #5 quickclk = ~quickclk;

  assign decoderes = lb_en ? codeout : force_val;

  fsk_link_framer #(
    .CLK_DIV      (CLK_DIV),
    .BIT_CYCLES   (BC),
    .SAMPLE_PHASE (BC / 2)
  ) dut (
    .quickclk   (quickclk),
    .reset      (reset),
    .outclk     (outclk),
    .code       (code),
    .send       (send),
    .codeout    (codeout),
    .sending    (sending),
    .decoderes  (decoderes),
    .codeoutseq (codeoutseq),
    .refresh    (refresh)
  );

  task automatic tick;
    @(posedge quickclk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; send = 1'b1; code = 11'h7FF; lb_en = 1'b1; force_val = 1'b0;
    repeat (3) tick();
    vectors++; if (outclk !== 1'b0) begin miscompares++; $display("FAIL reset_outclk got %b exp 0", outclk); end
    vectors++; if (codeout !== 1'b0) begin miscompares++; $display("FAIL reset_codeout got %b exp 0", codeout); end
    vectors++; if (sending !== 1'b0) begin miscompares++; $display("FAIL reset_sending got %b exp 0", sending); end
    vectors++; if (refresh !== 1'b0) begin miscompares++; $display("FAIL reset_refresh got %b exp 0", refresh); end
    vectors++; if (codeoutseq !== 11'h000) begin miscompares++; $display("FAIL reset_codeoutseq got %h exp 000", codeoutseq); end
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      vectors++;
      if (sending !== 1'b0) begin miscompares++; $display("FAIL held_send_start cyc %0d sending %b exp 0", n, sending); end
    end
    send = 1'b0;
    tick();
  endtask

  task automatic test_divider;
    int exp_o;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      exp_o = (n / (CLK_DIV / 2)) % 2;
      vectors++;
      if (outclk !== exp_o[0]) begin
        miscompares++; $display("FAIL divider edge %0d outclk %b exp %0d", n, outclk, exp_o);
      end
    end
  endtask

  // Sends word w; model: bit k of the frame is w[10 - k/BC], refresh once with the received word
  task automatic run_frame(input logic [WW-1:0] w, input int tail, input bit disturb,
                           input bit use_force, input logic fv);
    logic [WW-1:0] exp_w;
    logic [WW-1:0] seen;
    logic          exp_s, exp_c;
    int            ref_cnt;
    exp_w     = use_force ? {WW{fv}} : w;
    lb_en     = !use_force;
    force_val = fv;
    code      = w;
    send      = 1'b1;
    ref_cnt   = 0;
    seen      = '0;
    for (int k = 0; k < FRAME + tail; k++) begin
      tick();
      if (k < FRAME) begin exp_s = 1'b1; exp_c = w[WW - 1 - (k / BC)]; end
      else begin exp_s = 1'b0; exp_c = 1'b0; end
      vectors++;
      if (sending !== exp_s) begin miscompares++; $display("FAIL frame_sending w=%h k=%0d got %b exp %b", w, k, sending, exp_s); end
      vectors++;
      if (codeout !== exp_c) begin miscompares++; $display("FAIL frame_codeout w=%h k=%0d got %b exp %b", w, k, codeout, exp_c); end
      if (refresh === 1'b1) begin ref_cnt++; seen = codeoutseq; end
      if (disturb && k >= 2 * BC && k < 6 * BC) begin
        if (k % 7 == 0) send = ~send;
        code = WW'($urandom);
      end else if (disturb && k >= FRAME - 1) begin
        send = 1'b1;
      end else begin
        send = 1'b0;
      end
    end
    send = 1'b0;
    vectors++;
    if (ref_cnt != 1) begin miscompares++; $display("FAIL refresh_count w=%h got %0d exp 1", w, ref_cnt); end
    vectors++;
    if (seen !== exp_w) begin miscompares++; $display("FAIL refresh_word w=%h got %h exp %h", w, seen, exp_w); end
    vectors++;
    if (codeoutseq !== exp_w) begin miscompares++; $display("FAIL hold_word w=%h got %h exp %h", w, codeoutseq, exp_w); end
  endtask

  task automatic test_loopback;
    run_frame(11'h555, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_frame(11'h7FF, 1, 1'b0, 1'b0, 1'b0);
    run_frame(11'h001, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_during_shift;
    run_frame(WW'($urandom), 8, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (sending !== 1'b0) begin miscompares++; $display("FAIL ignore_extra_frame sending %b exp 0", sending); end
  endtask

  task automatic test_force_decoderes;
    run_frame(11'h000, 4, 1'b0, 1'b1, 1'b1);
    lb_en = 1'b1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_frame(WW'($urandom), int'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset;
    int ref_cnt;
    int busy;
    ref_cnt = 0;
    busy    = 0;
    lb_en   = 1'b1;
    code    = 11'h3A5;
    send    = 1'b1;
    for (int k = 0; k < 5 * BC + 3; k++) begin
      tick();
      send = 1'b0;
      if (refresh === 1'b1) ref_cnt++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++; if (sending !== 1'b0) begin miscompares++; $display("FAIL midreset_sending got %b exp 0", sending); end
    vectors++; if (codeout !== 1'b0) begin miscompares++; $display("FAIL midreset_codeout got %b exp 0", codeout); end
    vectors++; if (outclk !== 1'b0) begin miscompares++; $display("FAIL midreset_outclk got %b exp 0", outclk); end
    vectors++; if (codeoutseq !== 11'h000) begin miscompares++; $display("FAIL midreset_codeoutseq got %h exp 000", codeoutseq); end
    repeat (3) begin tick(); if (refresh === 1'b1) ref_cnt++; end
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (refresh === 1'b1) ref_cnt++;
      if (sending === 1'b1) busy++;
    end
    vectors++; if (ref_cnt != 0) begin miscompares++; $display("FAIL midreset_refresh got %0d exp 0", ref_cnt); end
    vectors++; if (busy != 0) begin miscompares++; $display("FAIL midreset_restart got %0d exp 0", busy); end
    vectors++; if (codeoutseq !== 11'h000) begin miscompares++; $display("FAIL midreset_hold got %h exp 000", codeoutseq); end
  endtask

  initial begin
    reset = 1'b1; send = 1'b0; code = '0; lb_en = 1'b1; force_val = 1'b0;
    test_reset();
    test_divider();
    test_loopback();
    test_mid_reset();
    test_back_to_back();
    test_ignore_during_shift();
    test_force_decoderes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
